// File: rtl/mine_dispatch_if.sv
// Dispatcher-to-hash-core-array bus: per-core status in, shared chunk bus and load/abort strobes out.
interface mine_dispatch_if #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned NONCE_W   = 32,
    parameter int unsigned CHUNK_W   = 8
);
    logic [NUM_CORES-1:0]         core_idle;
    logic [NUM_CORES-1:0]         core_found;
    logic [NUM_CORES*NONCE_W-1:0] core_found_nonce;
    logic [NUM_CORES-1:0]         core_load;
    logic [NONCE_W-1:0]           core_nonce;
    logic [CHUNK_W:0]             core_count;
    logic                         core_abort;

    modport master (
        input  core_idle, core_found, core_found_nonce,
        output core_load, core_nonce, core_count, core_abort
    );

    modport slave (
        output core_idle, core_found, core_found_nonce,
        input  core_load, core_nonce, core_count, core_abort
    );
endinterface

// File: rtl/mine_dispatch.sv
// Splits a nonce range into fixed-size chunks, deals them round-robin to hash cores,
// latches the first winner and reports exhaustion.
module mine_dispatch #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned NONCE_W   = 32,
    parameter int unsigned CHUNK_W   = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [NONCE_W-1:0] nonce_base,
    input  logic [NONCE_W-1:0] nonce_limit,
    mine_dispatch_if.master    cores,
    output logic               busy,
    output logic               found,
    output logic [NONCE_W-1:0] found_nonce,
    output logic               exhausted,
    output logic [NONCE_W-1:0] chunks_issued
);
    localparam int unsigned PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned SUM_W = NONCE_W + 1;
    localparam int unsigned CNT_W = CHUNK_W + 1;
    localparam logic [SUM_W-1:0] CHUNK_SIZE = SUM_W'(1) << CHUNK_W;

    typedef enum logic [2:0] {
        S_IDLE, S_DISPATCH, S_DRAIN, S_FOUND, S_EXHAUSTED
    } state_t;

    state_t state_q, state_d;

    logic [NONCE_W-1:0]   next_q, next_d;
    logic [NONCE_W-1:0]   limit_q, limit_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_CORES-1:0] load_q, load_d;
    logic [NONCE_W-1:0]   nonce_q, nonce_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 abort_q, abort_d;
    logic                 busy_q, busy_d;
    logic                 found_q, found_d;
    logic [NONCE_W-1:0]   found_nonce_q, found_nonce_d;
    logic                 exh_q, exh_d;
    logic [NONCE_W-1:0]   chunks_q, chunks_d;

    logic [NUM_CORES-1:0] avail;
    logic [PTR_W:0]       cand;
    logic [PTR_W-1:0]     pick_idx;
    logic                 pick_vld;
    logic                 any_found;
    logic [NONCE_W-1:0]   win_nonce;
    logic [SUM_W-1:0]     remaining;
    logic [SUM_W-1:0]     chunk_len;
    logic [SUM_W-1:0]     next_sum;
    logic                 last_fit;
    logic                 last_chunk;

    // Round-robin pick, winner select and chunk arithmetic; a core loaded last cycle is blacked out.
    always_comb begin
        avail    = cores.core_idle & ~load_q;
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + (PTR_W + 1)'(k);
            if (cand >= (PTR_W + 1)'(NUM_CORES)) begin
                cand = cand - (PTR_W + 1)'(NUM_CORES);
            end
            if (avail[cand[PTR_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[PTR_W-1:0];
            end
        end

        any_found = |cores.core_found;
        win_nonce = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (cores.core_found[i]) begin
                win_nonce = cores.core_found_nonce[i*NONCE_W +: NONCE_W];
            end
        end

        remaining  = {1'b0, limit_q} - {1'b0, next_q} + SUM_W'(1);
        last_fit   = (remaining <= CHUNK_SIZE);
        chunk_len  = last_fit ? remaining : CHUNK_SIZE;
        next_sum   = {1'b0, next_q} + chunk_len;
        last_chunk = last_fit | next_sum[NONCE_W];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_FOUND, S_EXHAUSTED: begin
                if (start) begin
                    state_d = (nonce_base > nonce_limit) ? S_EXHAUSTED : S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                if (any_found) begin
                    state_d = S_FOUND;
                end else if (pick_vld && last_chunk) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Wait out the cycle of the final load so the last core has dropped idle.
                if (any_found) begin
                    state_d = S_FOUND;
                end else if ((&cores.core_idle) && (load_q == '0)) begin
                    state_d = S_EXHAUSTED;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        next_d        = next_q;
        limit_d       = limit_q;
        ptr_d         = ptr_q;
        load_d        = '0;
        nonce_d       = nonce_q;
        count_d       = count_q;
        abort_d       = 1'b0;
        found_nonce_d = found_nonce_q;
        chunks_d      = chunks_q;
        case (state_q)
            S_IDLE, S_FOUND, S_EXHAUSTED: begin
                if (start) begin
                    next_d        = nonce_base;
                    limit_d       = nonce_limit;
                    ptr_d         = '0;
                    found_nonce_d = '0;
                    chunks_d      = '0;
                end
            end
            S_DISPATCH, S_DRAIN: begin
                if (any_found) begin
                    found_nonce_d = win_nonce;
                    abort_d       = 1'b1;
                end else if ((state_q == S_DISPATCH) && pick_vld) begin
                    load_d   = NUM_CORES'(1) << pick_idx;
                    nonce_d  = next_q;
                    count_d  = CNT_W'(chunk_len);
                    next_d   = next_sum[NONCE_W-1:0];
                    ptr_d    = (pick_idx == PTR_W'(NUM_CORES - 1)) ? '0 : pick_idx + PTR_W'(1);
                    chunks_d = (chunks_q == '1) ? chunks_q : chunks_q + NONCE_W'(1);
                end
            end
            default: ;
        endcase
        busy_d = (state_d == S_DISPATCH) || (state_d == S_DRAIN);
        found_d = (state_d == S_FOUND);
        exh_d   = (state_d == S_EXHAUSTED);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            next_q        <= '0;
            limit_q       <= '0;
            ptr_q         <= '0;
            load_q        <= '0;
            nonce_q       <= '0;
            count_q       <= '0;
            abort_q       <= 1'b0;
            busy_q        <= 1'b0;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
            exh_q         <= 1'b0;
            chunks_q      <= '0;
        end else begin
            next_q        <= next_d;
            limit_q       <= limit_d;
            ptr_q         <= ptr_d;
            load_q        <= load_d;
            nonce_q       <= nonce_d;
            count_q       <= count_d;
            abort_q       <= abort_d;
            busy_q        <= busy_d;
            found_q       <= found_d;
            found_nonce_q <= found_nonce_d;
            exh_q         <= exh_d;
            chunks_q      <= chunks_d;
        end
    end

    assign cores.core_load  = load_q;
    assign cores.core_nonce = nonce_q;
    assign cores.core_count = count_q;
    assign cores.core_abort = abort_q;
    assign busy             = busy_q;
    assign found            = found_q;
    assign found_nonce      = found_nonce_q;
    assign exhausted        = exh_q;
    assign chunks_issued    = chunks_q;
endmodule

// File: tb/tb_mine_dispatch.sv
// Bench for mine_dispatch: behavioural hash cores plus a queue of expected chunk loads.
module tb_mine_dispatch;
    localparam int unsigned NC = 4;
    localparam int unsigned NW = 32;
    localparam int unsigned CW = 8;
    localparam int BUSY_CYC = 10;

    typedef struct {
        int            core;
        logic [NW-1:0] nonce;
        logic [CW:0]   count;
    } load_t;

    typedef struct {
        logic [NW-1:0] base;
        logic [NW-1:0] limit;
        int unsigned   exp_chunks;
        logic [CW:0]   exp_last;
    } vec_t;

    logic          clock;
    logic          reset_n;
    logic          start;
    logic [NW-1:0] nonce_base;
    logic [NW-1:0] nonce_limit;
    logic          busy;
    logic          found;
    logic [NW-1:0] found_nonce;
    logic          exhausted;
    logic [NW-1:0] chunks_issued;

    mine_dispatch_if #(.NUM_CORES(NC), .NONCE_W(NW), .CHUNK_W(CW)) cores ();

    mine_dispatch #(.NUM_CORES(NC), .NONCE_W(NW), .CHUNK_W(CW)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .nonce_base   (nonce_base),
        .nonce_limit  (nonce_limit),
        .cores        (cores),
        .busy         (busy),
        .found        (found),
        .found_nonce  (found_nonce),
        .exhausted    (exhausted),
        .chunks_issued(chunks_issued)
    );

    load_t       exp_q[$];
    int          busy_cnt[NC];
    logic        force_en;
    logic [NC-1:0] force_idle;
    int          abort_cnt;
    logic [CW:0] last_count;
    int          checks;
    int          failures;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic observe_load();
        load_t e;
        int    idx;
        idx = -1;
        for (int i = 0; i < NC; i++) if (cores.core_load[i]) idx = i;
        check("load_onehot", 64'($countones(cores.core_load)), 64'(1));
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_load actual=core%0d nonce=0x%0h required=no load", idx, cores.core_nonce);
        end else begin
            e = exp_q.pop_front();
            check("load_core", 64'(idx), 64'(e.core));
            check("load_nonce", 64'(cores.core_nonce), 64'(e.nonce));
            check("load_count", 64'(cores.core_count), 64'(e.count));
        end
        last_count = cores.core_count;
    endtask

    // One clock: observe DUT just after the edge, then advance the core models.
    task automatic step();
        @(posedge clock);
        #1;
        if (cores.core_abort) abort_cnt++;
        if (cores.core_load != '0) observe_load();
        for (int i = 0; i < NC; i++) begin
            if (cores.core_load[i]) busy_cnt[i] = BUSY_CYC;
            else if (cores.core_abort) busy_cnt[i] = 0;
            else if (busy_cnt[i] > 0) busy_cnt[i]--;
            if (force_en) cores.core_idle[i] = force_idle[i];
            else          cores.core_idle[i] = (busy_cnt[i] == 0);
        end
    endtask

    task automatic pulse_start(input logic [NW-1:0] b, input logic [NW-1:0] l);
        nonce_base  = b;
        nonce_limit = l;
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    task automatic push_range(input logic [NW-1:0] b, input logic [NW-1:0] l);
        logic [NW:0] n;
        logic [NW:0] rem;
        load_t       e;
        int          k;
        n = {1'b0, b};
        k = 0;
        while (n <= {1'b0, l}) begin
            rem = {1'b0, l} - n + 33'd1;
            if (rem > 33'd256) rem = 33'd256;
            e.core  = k % NC;
            e.nonce = n[NW-1:0];
            e.count = rem[CW:0];
            exp_q.push_back(e);
            n = n + rem;
            k++;
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!(found || exhausted) && n < budget) begin
            step();
            n++;
        end
        check("done_in_budget", 64'(found | exhausted), 64'(1));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_found"}, 64'(found), 64'(0));
        check({tag, "_exhausted"}, 64'(exhausted), 64'(0));
        check({tag, "_chunks"}, 64'(chunks_issued), 64'(0));
        check({tag, "_found_nonce"}, 64'(found_nonce), 64'(0));
        check({tag, "_core_load"}, 64'(cores.core_load), 64'(0));
        check({tag, "_core_abort"}, 64'(cores.core_abort), 64'(0));
    endtask

    initial begin
        vec_t  vecs[4];
        load_t e;

        vecs[0] = '{base: 32'h0000_0000, limit: 32'h0000_03FF, exp_chunks: 4, exp_last: 9'd256};
        vecs[1] = '{base: 32'h0000_0010, limit: 32'h0000_011A, exp_chunks: 2, exp_last: 9'd11};
        vecs[2] = '{base: 32'hFFFF_FF80, limit: 32'hFFFF_FFFF, exp_chunks: 1, exp_last: 9'd128};
        vecs[3] = '{base: 32'h0000_0200, limit: 32'h0000_0100, exp_chunks: 0, exp_last: 9'd0};

        checks     = 0;
        failures   = 0;
        abort_cnt  = 0;
        last_count = '0;
        force_en   = 1'b0;
        force_idle = '0;
        reset_n    = 1'b0;
        start      = 1'b0;
        nonce_base = '0;
        nonce_limit = '0;
        for (int i = 0; i < NC; i++) busy_cnt[i] = 0;
        cores.core_idle        = '1;
        cores.core_found       = '0;
        cores.core_found_nonce = '0;

        repeat (2) @(posedge clock);
        #1;
        check_quiet("reset");
        reset_n = 1'b1;
        step();

        // Winner: cores 1 and 2 hit together, core 1 (lower index) takes it; later hits ignored.
        e = '{core: 0, nonce: 32'h0000_0000, count: 9'd256}; exp_q.push_back(e);
        e = '{core: 1, nonce: 32'h0000_0100, count: 9'd256}; exp_q.push_back(e);
        pulse_start(32'h0, 32'hFFFF);
        step();
        step();
        cores.core_found       = 4'b0110;
        cores.core_found_nonce = {32'h0, 32'hBBBB_0002, 32'hAAAA_0001, 32'h0};
        step();
        cores.core_found = '0;
        check("win_found", 64'(found), 64'(1));
        check("win_nonce", 64'(found_nonce), 64'hAAAA_0001);
        check("win_abort", 64'(cores.core_abort), 64'(1));
        check("win_busy", 64'(busy), 64'(0));
        check("win_no_load", 64'(cores.core_load), 64'(0));
        check("win_chunks", 64'(chunks_issued), 64'(2));
        step();
        check("abort_single", 64'(cores.core_abort), 64'(0));
        check("abort_count", 64'(abort_cnt), 64'(1));
        cores.core_found       = 4'b0001;
        cores.core_found_nonce = {96'h0, 32'hCCCC_0003};
        step();
        cores.core_found = '0;
        step();
        check("win_kept", 64'(found_nonce), 64'hAAAA_0001);
        check("win_found_held", 64'(found), 64'(1));
        check("win_queue_empty", 64'(exp_q.size()), 64'(0));

        // Only core 2 idle: loads every other cycle; a start mid-dispatch must be ignored.
        force_en         = 1'b1;
        force_idle       = 4'b0100;
        cores.core_idle  = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            e = '{core: 2, nonce: NW'(k * 256), count: 9'd256};
            exp_q.push_back(e);
        end
        pulse_start(32'h0, 32'hFFF);
        for (int s = 1; s <= 10; s++) begin
            if (s == 5) begin
                nonce_base = 32'h5000;
                start      = 1'b1;
            end
            step();
            start = 1'b0;
        end
        check("rr_queue_empty", 64'(exp_q.size()), 64'(0));
        check("rr_chunks", 64'(chunks_issued), 64'(5));
        check("rr_busy", 64'(busy), 64'(1));

        // Asynchronous reset in the middle of dispatch.
        #2;
        reset_n = 1'b0;
        #1;
        check_quiet("async_rst");
        check("async_rst_no_abort", 64'(abort_cnt), 64'(1));
        @(posedge clock);
        #1;
        reset_n  = 1'b1;
        force_en = 1'b0;
        for (int i = 0; i < NC; i++) busy_cnt[i] = 0;
        cores.core_idle = '1;
        exp_q.delete();
        step();

        for (int v = 0; v < 4; v++) begin
            for (int n = 0; n < 50 && cores.core_idle != '1; n++) step();
            push_range(vecs[v].base, vecs[v].limit);
            last_count = '0;
            pulse_start(vecs[v].base, vecs[v].limit);
            wait_done(300);
            check($sformatf("v%0d_exhausted", v), 64'(exhausted), 64'(1));
            check($sformatf("v%0d_found", v), 64'(found), 64'(0));
            check($sformatf("v%0d_busy", v), 64'(busy), 64'(0));
            check($sformatf("v%0d_chunks", v), 64'(chunks_issued), 64'(vecs[v].exp_chunks));
            check($sformatf("v%0d_last_count", v), 64'(last_count), 64'(vecs[v].exp_last));
            check($sformatf("v%0d_queue_empty", v), 64'(exp_q.size()), 64'(0));
            exp_q.delete();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
